// File: rtl/idli_pkg.sv
// Shared definitions for the idli instruction fetch path.
//   INSTR_W    : instruction width in bits
//   NIB_W      : SQI nibble width in bits
//   IBUF_DEPTH : default instruction buffer depth
//   instr_t    : one instruction word
//   ibuf_cnt_t : instruction buffer occupancy count (default depth)
package idli_pkg;

  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned IBUF_DEPTH = 2;
  localparam int unsigned IBUF_CNT_W = $clog2(IBUF_DEPTH) + 1;

  typedef logic [INSTR_W-1:0]    instr_t;
  typedef logic [IBUF_CNT_W-1:0] ibuf_cnt_t;

endpackage

// File: rtl/idli_ibuf_fifo_m.sv
// Generic DEPTH-entry synchronous FIFO used by the instruction buffer.
//   i_core_gck   : clock, rising edge
//   i_core_rst_n : asynchronous active-low reset (clears pointers, count, data)
//   i_push       : write i_push_data; accepted when not full or popping
//   i_pop        : advance head; ignored when empty
//   i_flush      : empty the FIFO, overrides push and pop
//   o_head       : head entry (combinational from storage)
//   o_cnt        : occupied entries
//   o_full       : cnt == DEPTH
//   o_empty      : cnt == 0
module idli_ibuf_fifo_m
  import idli_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = INSTR_W
) (
  input  logic                     i_core_gck,
  input  logic                     i_core_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_cnt,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (cnt == CNT_W'(DEPTH));
  assign o_empty = (cnt == '0);
  assign o_head  = mem[rd_ptr];
  assign o_cnt   = cnt;

  // A push into a full FIFO is still taken when the head leaves at the same edge.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= i_push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/idli_ibuf_m.sv
// Instruction fetch buffer between the SQI read path and the decoder.
// Assembles NIBBLES-nibble instructions (least-significant nibble first) and
// queues them in a DEPTH-entry FIFO presented to decode with valid/accept.
//   i_core_gck     : core clock, rising edge
//   i_core_rst_n   : asynchronous active-low reset
//   i_ibuf_nib     : SQI read nibble
//   i_ibuf_nib_vld : nibble valid this cycle
//   i_ibuf_flush   : drop all buffered and partial instructions
//   o_ibuf_instr   : head-of-FIFO instruction
//   o_ibuf_vld     : head entry valid
//   i_ibuf_acp     : decode accepts head entry
//   o_ibuf_space   : at least one free entry
//   o_ibuf_cnt     : occupied entries
//   o_ibuf_ovf     : sticky overflow (word dropped), cleared by flush
module idli_ibuf_m
  import idli_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       i_core_gck,
  input  logic                       i_core_rst_n,
  input  logic [NIB_W-1:0]           i_ibuf_nib,
  input  logic                       i_ibuf_nib_vld,
  input  logic                       i_ibuf_flush,
  output logic [NIB_W*NIBBLES-1:0]   o_ibuf_instr,
  output logic                       o_ibuf_vld,
  input  logic                       i_ibuf_acp,
  output logic                       o_ibuf_space,
  output logic [$clog2(DEPTH):0]     o_ibuf_cnt,
  output logic                       o_ibuf_ovf
);

  localparam int unsigned W    = NIB_W * NIBBLES;
  localparam int unsigned NC_W = $clog2(NIBBLES);

  logic [NC_W-1:0]    nib_cnt;
  logic [W-NIB_W-1:0] shreg;
  logic [W-1:0]       push_word;
  logic               word_done;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;

  assign word_done = i_ibuf_nib_vld && (nib_cnt == NC_W'(NIBBLES - 1));
  assign pop       = !fifo_empty && i_ibuf_acp;

  // The final nibble bypasses the shift register so the word is pushed at
  // the same edge it completes.
  always_comb begin
    push_word = {i_ibuf_nib, shreg};
  end

  always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) begin
      nib_cnt    <= '0;
      shreg      <= '0;
      o_ibuf_ovf <= 1'b0;
    end else if (i_ibuf_flush) begin
      nib_cnt    <= '0;
      o_ibuf_ovf <= 1'b0;
    end else begin
      if (i_ibuf_nib_vld) begin
        nib_cnt <= word_done ? '0 : nib_cnt + 1'b1;
        for (int unsigned k = 0; k < NIBBLES - 1; k++) begin
          if (nib_cnt == NC_W'(k)) begin
            shreg[k*NIB_W +: NIB_W] <= i_ibuf_nib;
          end
        end
      end
      if (word_done && fifo_full && !pop) begin
        o_ibuf_ovf <= 1'b1;
      end
    end
  end

  idli_ibuf_fifo_m #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_fifo (
    .i_core_gck   (i_core_gck),
    .i_core_rst_n (i_core_rst_n),
    .i_push       (word_done),
    .i_push_data  (push_word),
    .i_pop        (i_ibuf_acp),
    .i_flush      (i_ibuf_flush),
    .o_head       (o_ibuf_instr),
    .o_cnt        (o_ibuf_cnt),
    .o_full       (fifo_full),
    .o_empty      (fifo_empty)
  );

  assign o_ibuf_vld   = !fifo_empty;
  assign o_ibuf_space = !fifo_full;

endmodule

// File: doc/idli_ibuf_m.md
Name: idli_ibuf_m

Overview:
- Instruction fetch buffer between the SQI read path and the decoder.
- Collects the nibble stream returned by the SQI controller, assembles 16-bit instructions least-significant nibble first, and holds them in a small FIFO.
- Presents buffered instructions to decode with a valid/accept handshake, so fetch and decode are decoupled.
- Supports a flush on redirect and reports overflow if fetch outruns decode.

Parameters:
- DEPTH, 2, number of instruction entries in the FIFO (power of two, ≥2).
- NIBBLES, 4, nibbles per instruction; instruction width is 4*NIBBLES bits.

Ports:
- i_core_gck  in  1  core clock, all state on rising edge.
- i_core_rst_n  in  1  reset, asynchronous, active-low.
- i_ibuf_nib  in  4  SQI read data nibble.
- i_ibuf_nib_vld  in  1  nibble valid this cycle (registered SQI read-valid).
- i_ibuf_flush  in  1  discard all buffered and partial instructions.
- o_ibuf_instr  out  4*NIBBLES  head-of-FIFO instruction.
- o_ibuf_vld  out  1  head entry valid.
- i_ibuf_acp  in  1  decode accepts head entry.
- o_ibuf_space  out  1  at least one free FIFO entry.
- o_ibuf_cnt  out  $clog2(DEPTH)+1  occupied entries.
- o_ibuf_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (async, i_core_rst_n low):
  - nibble counter = 0, shift register = 0.
  - FIFO pointers = 0, all entries = 0.
  - o_ibuf_vld = 0, o_ibuf_instr = 0, o_ibuf_cnt = 0, o_ibuf_space = 1, o_ibuf_ovf = 0.
  - Reset mid-word discards the partial word.
- Assembly:
  - Nibble counter runs 0..NIBBLES-1 and advances only on i_ibuf_nib_vld.
  - Nibble k lands in bits [4k+3:4k].
  - A valid nibble at counter = NIBBLES-1 completes the word and wraps the counter to 0.
  - Gaps between valid nibbles are allowed and do not reset the counter.
- Push:
  - A completed word is written to the FIFO at the same clock edge as its last nibble, without occupying a separate assembly stage.
  - Latency: last nibble in cycle N gives o_ibuf_vld = 1 in cycle N+1 if the FIFO was empty.
- Pop:
  - A pop is o_ibuf_vld & i_ibuf_acp.
  - The head advances at the edge; the next entry is visible the following cycle.
  - i_ibuf_acp while o_ibuf_vld = 0 is ignored.
- Status outputs:
  - o_ibuf_instr is taken combinationally from the head entry; it holds the stale or reset value when o_ibuf_vld = 0.
  - o_ibuf_vld = (cnt != 0).
  - o_ibuf_space = (cnt < DEPTH).
  - All three are derived from registered state only.
- Simultaneous push and pop:
  - Allowed at any occupancy, including full.
  - cnt is unchanged, both pointers advance, and the word is accepted.
- Overflow:
  - Push while cnt = DEPTH and no pop in the same cycle means the word is dropped.
  - FIFO contents are unchanged and o_ibuf_ovf is set the next cycle.
  - o_ibuf_ovf stays set until flush or reset.
- Empty: a pop is impossible; cnt never underflows.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: cnt = 0, pointers = 0, nibble counter = 0, o_ibuf_ovf = 0, o_ibuf_vld = 0.
  - A nibble presented in the flush cycle is discarded.
  - Entry data need not be cleared.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; cnt holds full/empty.

Decomposition:
- Shared package idli_pkg:
  - instruction-width localparam (16) and nibble width (4).
  - typedef for the instruction word.
  - typedef for the FIFO count.
- One natural sub-module: idli_ibuf_fifo_m, a generic DEPTH-entry synchronous FIFO with push, pop, flush, count, full and empty.
  - Assembly counter, shift register and overflow flag stay in idli_ibuf_m.

Test Plan:
- Reset then nibbles 0x4,0x3,0x2,0x1 on consecutive cycles -> o_ibuf_vld rises the cycle after the 4th nibble, o_ibuf_instr = 0x1234, cnt = 1.
- Nibbles with 1-cycle gaps 0xD,idle,0xA,idle,0xE,idle,0xB, acp held 0 -> instr = 0xBEAD; a second word 0x5678 -> cnt = 2, o_ibuf_space = 0.
- FIFO full (0x1111, 0x2222), third word 0x3333 with acp = 0 -> o_ibuf_ovf = 1, head still 0x1111, cnt = 2; pop twice -> 0x2222 then empty, 0x3333 never appears.
- FIFO full with acp = 1 in the cycle the third word completes -> cnt stays 2, sequence out 0x2222 then 0x3333, o_ibuf_ovf = 0.
- Two nibbles of a word, then flush together with a valid nibble, then 0x8,0x7,0x6,0x5 -> cnt = 0 and vld = 0 after flush; next instr = 0x5678 (counter realigned).
- Reset asserted asynchronously mid-word with cnt = 1 -> all outputs at reset values immediately; a following full word assembles correctly.
